// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: machine word and fetch FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam word_t INSTR_BYTES = 32'd4;

  function automatic word_t next_word_addr(input word_t addr);
    return addr + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/ifid_latch.sv
// rtl/ifid_latch.sv - IF/ID pipeline register with enable, clear and load controls.
module ifid_latch
  import cpu_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] new_instr,
  input  logic [31:0] new_pc,
  input  logic [31:0] new_npc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] npc
);

  word_t instr_q, pc_q, npc_q;
  logic  valid_q;

  // Payload fields only change on a load; a clear or bubble drops valid alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      npc_q   <= '0;
    end else if (en) begin
      if (clr) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
        instr_q <= new_instr;
        pc_q    <= new_pc;
        npc_q   <= new_npc;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;
  assign npc   = npc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, icache request, IF/ID load.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_npc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_miss
);

  fetch_state_t state, state_next;
  word_t        pc, pc_next, pc_plus4;
  logic         latch_en, latch_clr, latch_load;
  logic         unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];
  assign pc_plus4 = next_word_addr(pc);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      pc    <= PC_INIT;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Event priority: halt > redirect > flush > stall > ihit.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    latch_en   = 1'b1;
    latch_clr  = 1'b0;
    latch_load = 1'b0;
    if (state == RUN) begin
      if (halt) begin
        state_next = HALTED;
        latch_clr  = 1'b1;
      end else if (redirect) begin
        pc_next   = {redirect_pc[31:2], 2'b00};
        latch_clr = 1'b1;
      end else if (flush) begin
        latch_clr = 1'b1;
      end else if (stall) begin
        latch_en = 1'b0;
      end else if (ihit) begin
        pc_next    = pc_plus4;
        latch_load = 1'b1;
      end
    end else begin
      latch_en = 1'b0;
    end
  end

  assign iREN  = (state == RUN) && !stall && !RST;
  assign iaddr = pc;

  ifid_latch u_ifid_latch (
    .clk       (CLK),
    .rst       (RST),
    .en        (latch_en),
    .clr       (latch_clr),
    .load      (latch_load),
    .new_instr (iload),
    .new_pc    (pc),
    .new_npc   (pc_plus4),
    .valid     (ifid_valid),
    .instr     (ifid_instr),
    .pc        (ifid_pc),
    .npc       (ifid_npc)
  );

`ifdef FETCH_PERF_EN
  word_t fetched_q, miss_q;

  // Both conditions are impossible in HALTED, so the counters freeze there.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetched_q <= '0;
      miss_q    <= '0;
    end else begin
      if (latch_load) fetched_q <= fetched_q + 32'd1;
      if (iREN && !ihit) miss_q <= miss_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_miss    = miss_q;
`else
  assign perf_fetched = '0;
  assign perf_miss    = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector table plus randomized run against a reference model.
module tb_fetch_stage;

  logic        CLK, RST, iREN, ihit, stall, flush, redirect, halt, ifid_valid;
  logic [31:0] iaddr, iload, redirect_pc, ifid_instr, ifid_pc, ifid_npc;
  logic [31:0] perf_fetched, perf_miss;

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_npc(ifid_npc), .perf_fetched(perf_fetched), .perf_miss(perf_miss)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_ipc, m_npc, m_fetched, m_miss;
  logic        m_halted, m_valid;

  typedef struct {
    logic [5:0]  ctl;   // {rst, ihit, stall, flush, redirect, halt}
    logic [31:0] iload;
    logic [31:0] rpc;
    logic        e_iren;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic [31:0] e_iaddr;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] perf_exp(input logic [31:0] cnt);
`ifdef FETCH_PERF_EN
    return cnt;
`else
    return 32'd0 & cnt;
`endif
  endfunction

  function automatic vec_t row(input logic [5:0] ctl, input logic [31:0] ld, input logic [31:0] rpc,
                               input logic e_iren, input logic e_valid, input logic [31:0] ei,
                               input logic [31:0] ep, input logic [31:0] en, input logic [31:0] ea);
    vec_t r;
    r.ctl = ctl; r.iload = ld; r.rpc = rpc; r.e_iren = e_iren; r.e_valid = e_valid;
    r.e_instr = ei; r.e_pc = ep; r.e_npc = en; r.e_iaddr = ea;
    return r;
  endfunction

  // One clock cycle: drive inputs, check combinational outputs, advance the
  // model by the fetch rules, then check the registered outputs after the edge.
  task automatic step(input logic [5:0] ctl, input logic [31:0] ld, input logic [31:0] rpc);
    logic e_iren;
    {RST, ihit, stall, flush, redirect, halt} = ctl;
    iload = ld;
    redirect_pc = rpc;
    #1;
    e_iren = !m_halted && !stall && !RST;
    chk("model_iren", {31'd0, iREN}, {31'd0, e_iren});
    chk("model_iaddr_pre", iaddr, m_pc);
    if (RST) begin
      m_pc = 32'h0; m_halted = 1'b0; m_valid = 1'b0;
      m_instr = 0; m_ipc = 0; m_npc = 0; m_fetched = 0; m_miss = 0;
    end else if (!m_halted) begin
      if (e_iren && !ihit) m_miss++;
      if (halt) begin
        m_halted = 1'b1; m_valid = 1'b0;
      end else if (redirect) begin
        m_pc = rpc & ~32'd3; m_valid = 1'b0;
      end else if (flush) begin
        m_valid = 1'b0;
      end else if (stall) begin
        m_valid = m_valid;
      end else if (ihit) begin
        m_instr = ld; m_ipc = m_pc; m_npc = m_pc + 32'd4; m_pc = m_pc + 32'd4;
        m_valid = 1'b1; m_fetched++;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge CLK);
    #1;
    chk("model_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    chk("model_instr", ifid_instr, m_instr);
    chk("model_ifid_pc", ifid_pc, m_ipc);
    chk("model_ifid_npc", ifid_npc, m_npc);
    chk("model_iaddr", iaddr, m_pc);
    chk("model_perf_fetched", perf_fetched, perf_exp(m_fetched));
    chk("model_perf_miss", perf_miss, perf_exp(m_miss));
  endtask

  initial begin
    logic [5:0] ctl;
    logic       pre_iren;
    tbl[0]  = row(6'b100000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tbl[1]  = row(6'b010000, 32'h2001_0005, 32'h0, 1'b1, 1'b1, 32'h2001_0005, 32'h0, 32'h4, 32'h4);
    tbl[2]  = row(6'b010000, 32'h2001_0006, 32'h0, 1'b1, 1'b1, 32'h2001_0006, 32'h4, 32'h8, 32'h8);
    tbl[3]  = row(6'b010000, 32'h2001_0007, 32'h0, 1'b1, 1'b1, 32'h2001_0007, 32'h8, 32'hC, 32'hC);
    tbl[4]  = row(6'b010000, 32'h2001_0008, 32'h0, 1'b1, 1'b1, 32'h2001_0008, 32'hC, 32'h10, 32'h10);
    for (int i = 5; i < 8; i++)
      tbl[i] = row(6'b000000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h2001_0008, 32'hC, 32'h10, 32'h10);
    tbl[8]  = row(6'b010000, 32'h1111_1111, 32'h0, 1'b1, 1'b1, 32'h1111_1111, 32'h10, 32'h14, 32'h14);
    tbl[9]  = row(6'b011000, 32'h2222_2222, 32'h0, 1'b0, 1'b1, 32'h1111_1111, 32'h10, 32'h14, 32'h14);
    tbl[10] = tbl[9];
    tbl[11] = row(6'b010000, 32'h3333_3333, 32'h0, 1'b1, 1'b1, 32'h3333_3333, 32'h14, 32'h18, 32'h18);
    tbl[12] = row(6'b010010, 32'h4444_4444, 32'h43, 1'b1, 1'b0, 32'h3333_3333, 32'h14, 32'h18, 32'h40);
    tbl[13] = row(6'b010100, 32'h5555_5555, 32'h0, 1'b1, 1'b0, 32'h3333_3333, 32'h14, 32'h18, 32'h40);
    tbl[14] = row(6'b010000, 32'h6666_6666, 32'h0, 1'b1, 1'b1, 32'h6666_6666, 32'h40, 32'h44, 32'h44);
    tbl[15] = row(6'b000010, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h6666_6666, 32'h40, 32'h44, 32'hFFFF_FFFC);
    tbl[16] = row(6'b010000, 32'h7777_7777, 32'h0, 1'b1, 1'b1, 32'h7777_7777, 32'hFFFF_FFFC, 32'h0, 32'h0);
    tbl[17] = row(6'b010011, 32'h8888_8888, 32'h100, 1'b1, 1'b0, 32'h7777_7777, 32'hFFFF_FFFC, 32'h0, 32'h0);
    tbl[18] = row(6'b010000, 32'h8888_8888, 32'h0, 1'b0, 1'b0, 32'h7777_7777, 32'hFFFF_FFFC, 32'h0, 32'h0);
    tbl[19] = tbl[18];
    tbl[20] = row(6'b100000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tbl[21] = row(6'b010000, 32'h9999_9999, 32'h0, 1'b1, 1'b1, 32'h9999_9999, 32'h0, 32'h4, 32'h4);

    {RST, ihit, stall, flush, redirect, halt} = 6'b100000;
    iload = 0; redirect_pc = 0;
    m_pc = 0; m_halted = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_npc = 0;
    m_fetched = 0; m_miss = 0;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 22; i++) begin
      {RST, ihit, stall, flush, redirect, halt} = tbl[i].ctl;
      #1;
      pre_iren = iREN;
      step(tbl[i].ctl, tbl[i].iload, tbl[i].rpc);
      chk($sformatf("vec%0d_iren", i), {31'd0, pre_iren}, {31'd0, tbl[i].e_iren});
      chk($sformatf("vec%0d_valid", i), {31'd0, ifid_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d_instr", i), ifid_instr, tbl[i].e_instr);
      chk($sformatf("vec%0d_ifid_pc", i), ifid_pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_ifid_npc", i), ifid_npc, tbl[i].e_npc);
      chk($sformatf("vec%0d_iaddr", i), iaddr, tbl[i].e_iaddr);
      if (i == 4) chk("perf_fetched_after_4", perf_fetched, perf_exp(32'd4));
      if (i == 7) chk("perf_miss_after_3", perf_miss, perf_exp(32'd3));
    end

    // Randomized traffic, including rare halts and the resets that leave them.
    for (int n = 0; n < 400; n++) begin
      ctl[5] = ($urandom_range(99) < 3);
      ctl[4] = ($urandom_range(99) < 60);
      ctl[3] = ($urandom_range(99) < 20);
      ctl[2] = ($urandom_range(99) < 10);
      ctl[1] = ($urandom_range(99) < 10);
      ctl[0] = ($urandom_range(99) < 2);
      step(ctl, $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
